// File: rtl/alu_seq_pkg.sv
// Shared opcode map, multiply/divide FSM state type and opcode helpers
// for the alu_seq execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_NOR   = 4'b0100;
  localparam logic [3:0] ALU_SLTU  = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_MULT  = 4'b1000;
  localparam logic [3:0] ALU_MULTU = 4'b1001;
  localparam logic [3:0] ALU_DIV   = 4'b1010;
  localparam logic [3:0] ALU_DIVU  = 4'b1011;
  localparam logic [3:0] ALU_MFHI  = 4'b1100;
  localparam logic [3:0] ALU_MFLO  = 4'b1101;
  localparam logic [3:0] ALU_MTHI  = 4'b1110;
  localparam logic [3:0] ALU_MTLO  = 4'b1111;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FINISH
  } md_state_t;

  // Any of MULT, MULTU, DIV, DIVU.
  function automatic logic is_muldiv(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

  // DIV or DIVU.
  function automatic logic is_div(input logic [3:0] op);
    return op[3:1] == 3'b101;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Execute-stage ALU bus: operands, opcode, start handshake and results.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       aluControl;
  logic             start;
  logic [WIDTH-1:0] aluResult;
  logic             zero;
  logic             busy;
  logic             done;
  logic             divByZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output a, b, aluControl, start,
    input  aluResult, zero, busy, done, divByZero, hi, lo
  );

  modport slave (
    input  a, b, aluControl, start,
    output aluResult, zero, busy, done, divByZero, hi, lo
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// muldiv_unit: iterative radix-2 shift-add multiplier and restoring divider
// with sign fix-up. One iteration per RUN cycle, WIDTH iterations total.
// Divider datapath present only when ALU_DIV_EN is defined.
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               sgn,
`ifdef ALU_DIV_EN
  input  logic               div_sel,
  output logic               div_zero,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               wr,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  md_state_t        state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, mag_m;
  logic [WIDTH-1:0] step_hi, step_lo, abs_a, abs_b;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod;
  logic             neg_q, last;
`ifdef ALU_DIV_EN
  logic [WIDTH-1:0] a_raw, all_ones;
  logic [WIDTH:0]   shifted, trial;
  logic             div_op, neg_r, b_zero;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nx = state;
    last     = (cnt == CW'(WIDTH - 1));
    case (state)
      MD_IDLE:   if (go)   state_nx = MD_RUN;
      MD_RUN:    if (last) state_nx = MD_FINISH;
      MD_FINISH: state_nx = MD_IDLE;
      default:   state_nx = MD_IDLE;
    endcase
    busy = (state != MD_IDLE);
    wr   = (state == MD_FINISH);
  end

  // One iteration: multiply adds/shifts {acc_hi,acc_lo} right; divide shifts
  // the dividend out of acc_lo into the remainder in acc_hi, quotient bits in.
  always_comb begin
    abs_a   = (sgn && a[WIDTH-1]) ? -a : a;
    abs_b   = (sgn && b[WIDTH-1]) ? -b : b;
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_m} : '0);
    step_hi = sum[WIDTH:1];
    step_lo = {sum[0], acc_lo[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    trial   = shifted - {1'b0, mag_m};
    if (div_op) begin
      // Remainder stays below the divisor, so bit WIDTH of trial is its sign.
      step_hi = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], ~trial[WIDTH]};
    end
`endif
  end

  // Operand latch at start, iteration registers, done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mag_m  <= '0;
      neg_q  <= 1'b0;
      done   <= 1'b0;
`ifdef ALU_DIV_EN
      a_raw    <= '0;
      div_op   <= 1'b0;
      neg_r    <= 1'b0;
      b_zero   <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      done <= (state == MD_FINISH);
      case (state)
        MD_IDLE: if (go) begin
          cnt    <= '0;
          acc_hi <= '0;
          neg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          mag_m  <= abs_a;
          acc_lo <= abs_b;
`ifdef ALU_DIV_EN
          a_raw    <= a;
          div_op   <= div_sel;
          neg_r    <= sgn & a[WIDTH-1];
          b_zero   <= (b == '0);
          div_zero <= 1'b0;
          if (div_sel) begin
            mag_m  <= abs_b;
            acc_lo <= abs_a;
          end
`endif
        end
        MD_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
        end
`ifdef ALU_DIV_EN
        MD_FINISH: div_zero <= div_op & b_zero;
`endif
        default: ;
      endcase
    end
  end

  // Sign fix-up of the magnitude result; divide-by-zero overrides it.
  always_comb begin
    prod   = {acc_hi, acc_lo};
    result = neg_q ? -prod : prod;
`ifdef ALU_DIV_EN
    all_ones = '1;
    if (div_op) begin
      if (b_zero) result = {a_raw, all_ones};
      else        result = {(neg_r ? -acc_hi : acc_hi), (neg_q ? -acc_lo : acc_lo)};
    end
`endif
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: single-cycle ALU plus HI/LO registers and start decoding for the
// multi-cycle multiply/divide engine. Optional divider: define ALU_DIV_EN.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);

  logic               md_busy, md_wr, md_done, md_go, md_signed, accept;
  logic [2*WIDTH-1:0] md_result;
  logic [WIDTH-1:0]   hi_q, lo_q, result;
`ifdef ALU_DIV_EN
  logic               md_div, md_dz;
`endif

  // Start is honoured only while the engine is idle.
  always_comb begin
    accept    = bus.start && !md_busy;
    md_signed = ~bus.aluControl[0];
`ifdef ALU_DIV_EN
    md_div = is_div(bus.aluControl);
    md_go  = accept && is_muldiv(bus.aluControl);
`else
    md_go  = accept && (bus.aluControl == ALU_MULT || bus.aluControl == ALU_MULTU);
`endif
  end

  muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .go      (md_go),
    .sgn     (md_signed),
`ifdef ALU_DIV_EN
    .div_sel (md_div),
    .div_zero(md_dz),
`endif
    .a       (bus.a),
    .b       (bus.b),
    .busy    (md_busy),
    .wr      (md_wr),
    .done    (md_done),
    .result  (md_result)
  );

  // Single-cycle result; start-only codes read as zero.
  always_comb begin
    result = '0;
    case (bus.aluControl)
      ALU_AND:  result = bus.a & bus.b;
      ALU_OR:   result = bus.a | bus.b;
      ALU_ADD:  result = bus.a + bus.b;
      ALU_XOR:  result = bus.a ^ bus.b;
      ALU_NOR:  result = ~(bus.a | bus.b);
      ALU_SUB:  result = bus.a - bus.b;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      ALU_MFHI: result = hi_q;
      ALU_MFLO: result = lo_q;
      default:  result = '0;
    endcase
  end

  // HI/LO: written by engine completion or by an accepted MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (md_wr) begin
      hi_q <= md_result[2*WIDTH-1:WIDTH];
      lo_q <= md_result[WIDTH-1:0];
    end else if (accept && bus.aluControl == ALU_MTHI) begin
      hi_q <= bus.a;
    end else if (accept && bus.aluControl == ALU_MTLO) begin
      lo_q <= bus.a;
    end
  end

  assign bus.aluResult = result;
  assign bus.zero      = (result == '0);
  assign bus.busy      = md_busy;
  assign bus.done      = md_done;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
`ifdef ALU_DIV_EN
  assign bus.divByZero = md_dz;
`else
  assign bus.divByZero = 1'b0;
`endif

endmodule
